// File: rtl/uart_boot_loader.sv
// Boot loader between the UART and the core. It waits for a sync byte, then loads a
// length-prefixed image into imem, acknowledges the host, and afterwards forwards rx bytes to the core.
//
// state  | meaning
// S_SYNC | waiting for SYNC_BYTE
// S_LEN  | shifting in the 4-byte big-endian word count
// S_DATA | shifting in image words and writing each one to imem
// S_ACK  | waiting for uart_tx to go idle, then sending ACK_BYTE
// S_RUN  | core released; rx bytes are forwarded to the core input port
// S_ERR  | load failed; stays here until reset
module uart_boot_loader #(
  parameter int          ADDR_W    = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter logic [7:0]  ACK_BYTE  = 8'h55
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              ferr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              in_valid,
  output logic [7:0]        in_data,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_SYNC, S_LEN, S_DATA, S_ACK, S_RUN, S_ERR
  } state_t;

  // One extra bit so that a full 2**ADDR_W-word image can be counted.
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   index;
  logic [31:0]       next_word;
  logic              last_byte;
  logic              byte_ok;
  logic              len_too_big;

  assign next_word   = {shreg, rx_data};
  assign last_byte   = (byte_cnt == 2'd3);
  assign byte_ok     = rx_ready && !ferr;
  assign len_too_big = ({1'b0, next_word} > MAX_WORDS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    cpu_run   = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_SYNC: begin
        if (byte_ok && rx_data == SYNC_BYTE) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (rx_ready) begin
          if (ferr) state_nxt = S_ERR;
          else if (last_byte) begin
            if (next_word == 32'd0) state_nxt = S_ACK;
            else if (len_too_big)   state_nxt = S_ERR;
            else                    state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_ready) begin
          if (ferr) state_nxt = S_ERR;
          else if (last_byte && (index + 1'b1) == word_cnt) state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data   = ACK_BYTE;
          state_nxt = S_RUN;
        end
      end
      S_RUN: cpu_run  = 1'b1;
      S_ERR: load_err = 1'b1;
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      word_cnt   <= '0;
      index      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      in_valid   <= 1'b0;
      in_data    <= 8'h00;
    end else begin
      imem_we  <= 1'b0;
      in_valid <= 1'b0;
      case (state)
        S_SYNC: begin
          byte_cnt <= 2'd0;
          shreg    <= 24'd0;
        end
        S_LEN: begin
          if (byte_ok) begin
            shreg    <= next_word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              word_cnt <= next_word[ADDR_W:0];
              index    <= '0;
            end
          end
        end
        S_DATA: begin
          if (byte_ok) begin
            shreg    <= next_word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= index[ADDR_W-1:0];
              imem_wdata <= next_word;
              index      <= index + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (byte_ok) begin
            in_valid <= 1'b1;
            in_data  <= rx_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed scenarios plus random byte streams,
// with expectations taken from a stream-level model of the boot protocol.
module tb_uart_boot_loader;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready = 1'b0;
  logic              ferr = 1'b0;
  logic              tx_busy = 1'b0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              load_err;

  uart_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_ready(rx_ready), .ferr(ferr),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .in_valid(in_valid), .in_data(in_data), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // observed activity
  int          got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  got_fwd[$];
  int          got_tx = 0;
  int          bad_tx = 0;
  int          both_hi = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (imem_we) begin
        got_addr.push_back(int'(imem_addr));
        got_data.push_back(imem_wdata);
      end
      if (tx_start) begin
        got_tx++;
        if (tx_data !== 8'h55) bad_tx++;
      end
      if (in_valid) got_fwd.push_back(in_data);
      if (imem_we && in_valid) both_hi++;
    end
  end

  // stimulus stream and expectations
  logic [7:0]  byte_q[$];
  logic        ferr_q[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  exp_fwd[$];
  int          exp_tx;
  logic        exp_run;
  logic        exp_err;

  task automatic push_b(input logic [7:0] b, input logic f);
    byte_q.push_back(b);
    ferr_q.push_back(f);
  endtask

  task automatic push_w(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) push_b(w[k*8 +: 8], 1'b0);
  endtask

  // Parses the byte stream the way the host protocol defines it. Assumes
  // enough idle time after the last image word that the ack completes first.
  task automatic run_model();
    localparam int HUNT = 0, LENGTH = 1, IMAGE = 2, RUNNING = 3, FAILED = 4;
    int phase = HUNT;
    int cnt = 0;
    longint unsigned n = 0;
    logic [31:0] w = 0;
    longint unsigned idx = 0;
    exp_addr.delete(); exp_data.delete(); exp_fwd.delete();
    exp_tx = 0;
    foreach (byte_q[i]) begin
      logic [7:0] b;
      logic f;
      b = byte_q[i];
      f = ferr_q[i];
      case (phase)
        HUNT: if (!f && b == 8'hAA) begin phase = LENGTH; cnt = 0; n = 0; end
        LENGTH: begin
          if (f) phase = FAILED;
          else begin
            n = (n << 8) | b;
            cnt++;
            if (cnt == 4) begin
              if (n == 0) begin phase = RUNNING; exp_tx = 1; end
              else if (n > (longint'(1) << ADDR_W)) phase = FAILED;
              else begin phase = IMAGE; cnt = 0; idx = 0; end
            end
          end
        end
        IMAGE: begin
          if (f) phase = FAILED;
          else begin
            w = {w[23:0], b};
            cnt++;
            if (cnt == 4) begin
              exp_addr.push_back(int'(idx));
              exp_data.push_back(w);
              idx++;
              cnt = 0;
              if (idx == n) begin phase = RUNNING; exp_tx = 1; end
            end
          end
        end
        RUNNING: if (!f) exp_fwd.push_back(b);
        default: ;
      endcase
    end
    exp_run = (phase == RUNNING);
    exp_err = (phase == FAILED);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f);
    @(posedge clk); #1;
    rx_data  = b;
    ferr     = f;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    ferr     = 1'b0;
    repeat ($urandom_range(2, 5)) @(posedge clk);
  endtask

  task automatic send_stream();
    foreach (byte_q[i]) send_byte(byte_q[i], ferr_q[i]);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    rx_ready = 1'b0;
    ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got_addr.delete(); got_data.delete(); got_fwd.delete();
    got_tx = 0; bad_tx = 0; both_hi = 0;
    byte_q.delete(); ferr_q.delete();
    rstn = 1'b1;
  endtask

  task automatic check_outcome(input string name);
    int nw;
    int nf;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({name, ".nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s.waddr%0d", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s.wdata%0d", name, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
    chk({name, ".ntx"}, 64'(got_tx), 64'(exp_tx));
    chk({name, ".txdata"}, 64'(bad_tx), 64'd0);
    chk({name, ".nfwd"}, 64'(got_fwd.size()), 64'(exp_fwd.size()));
    nf = (got_fwd.size() < exp_fwd.size()) ? got_fwd.size() : exp_fwd.size();
    for (int i = 0; i < nf; i++)
      chk($sformatf("%s.fwd%0d", name, i), 64'(got_fwd[i]), 64'(exp_fwd[i]));
    chk({name, ".cpu_run"}, 64'(cpu_run), 64'(exp_run));
    chk({name, ".load_err"}, 64'(load_err), 64'(exp_err));
    chk({name, ".overlap"}, 64'(both_hi), 64'd0);
  endtask

  task automatic directed(input string name);
    run_model();
    send_stream();
    check_outcome(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.tx_start", 64'(tx_start), 64'd0);
    chk("rst.tx_data", 64'(tx_data), 64'd0);
    chk("rst.imem_we", 64'(imem_we), 64'd0);
    chk("rst.imem_addr", 64'(imem_addr), 64'd0);
    chk("rst.imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst.cpu_run", 64'(cpu_run), 64'd0);
    chk("rst.in_valid", 64'(in_valid), 64'd0);
    chk("rst.in_data", 64'(in_data), 64'd0);
    chk("rst.load_err", 64'(load_err), 64'd0);

    apply_reset();
    push_b(8'hAA, 0); push_w(32'd2); push_w(32'h11223344); push_w(32'h55667788);
    directed("two_words");

    apply_reset();
    push_b(8'h3C, 0); push_b(8'h00, 0); push_b(8'hAA, 0); push_w(32'd0);
    directed("junk_zero_len");

    // ack deferred while uart_tx is busy
    apply_reset();
    tx_busy = 1'b1;
    push_b(8'hAA, 0); push_w(32'd1); push_w(32'hCAFEF00D);
    run_model();
    send_stream();
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("busy.tx_held", 64'(got_tx), 64'd0);
    chk("busy.run_held", 64'(cpu_run), 64'd0);
    chk("busy.nwrites", 64'(got_addr.size()), 64'd1);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    check_outcome("busy");

    apply_reset();
    push_b(8'hAA, 0); push_w(32'd2); push_w(32'h11223344);
    push_b(8'h55, 0); push_b(8'h66, 1); push_b(8'h77, 0); push_b(8'h88, 0);
    push_w(32'h99AABBCC); push_b(8'hAA, 0);
    directed("ferr_word1");

    apply_reset();
    push_b(8'hAA, 0); push_w(32'h0000_4001); push_w(32'h01020304);
    directed("oversize");

    apply_reset();
    push_b(8'hAA, 0); push_w(32'h0000_4000);
    run_model();
    send_stream();
    check_outcome("max_len_accepted");

    apply_reset();
    push_b(8'hAA, 0); push_w(32'd0); push_b(8'h12, 0); push_b(8'hAA, 0); push_b(8'h33, 1);
    directed("run_forward");

    // reset in the middle of an image
    apply_reset();
    push_b(8'hAA, 0); push_w(32'd3); push_w(32'hDEADBEEF); push_b(8'h01, 0); push_b(8'h02, 0);
    send_stream();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst.partial", 64'(got_addr.size()), 64'd1);
    apply_reset();
    push_b(8'hAA, 0); push_w(32'd1); push_w(32'h0BADCAFE);
    directed("midrst.reload");

    for (int t = 0; t < 20; t++) begin
      int nj;
      int nw;
      int nr;
      apply_reset();
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) push_b(8'($urandom), ($urandom_range(0, 7) == 0));
      push_b(8'hAA, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) begin
        push_w(32'h0000_4001 + 32'($urandom_range(0, 3)));
        nw = 2;
      end else begin
        nw = $urandom_range(0, 4);
        push_w(32'(nw));
      end
      for (int j = 0; j < nw * 4; j++) push_b(8'($urandom), ($urandom_range(0, 31) == 0));
      nr = $urandom_range(0, 4);
      for (int j = 0; j < nr; j++) push_b(8'($urandom), ($urandom_range(0, 5) == 0));
      directed($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
